// File: rtl/fp_addsub.sv
// fp_addsub: parameterised IEEE-754 binary adder/subtractor with a single
// registered output stage (1-cycle latency, full throughput).
// Optional feature macro: FPADDSUB_SUBNORMAL_EN
//   defined   -> gradual underflow (subnormal inputs and results)
//   undefined -> flush-to-zero on inputs and on underflowing results
module fp_addsub #(
    parameter int N_BIT   = 64,
    parameter int EXP_BIT = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N_BIT-1:0] a,
    input  logic [N_BIT-1:0] b,
    input  logic             addnot_sub,
    output logic [N_BIT-1:0] out,
    output logic             out_valid
);

    localparam int M    = N_BIT - EXP_BIT - 1;
    // working significand: hidden | mantissa | guard | round | sticky
    localparam int W    = M + 4;
    localparam int EMAX = (1 << EXP_BIT) - 1;

    localparam logic [N_BIT-1:0] QNAN = {1'b0, {EXP_BIT{1'b1}}, 1'b1, {(M-1){1'b0}}};

    // leading-zero count of the working significand (W when all zero)
    function automatic int unsigned lzc(input logic [W-1:0] v);
        int unsigned n;
        n = W;
        for (int unsigned i = 0; i < W; i++) begin
            if (v[i]) n = W - 1 - i;
        end
        return n;
    endfunction

    // field extraction
    logic               sa, sb;
    logic [EXP_BIT-1:0] ea_f, eb_f;
    logic [M-1:0]       ma_f, mb_f;
    logic               a_nan, b_nan, a_inf, b_inf;

    assign sa   = a[N_BIT-1];
    assign sb   = b[N_BIT-1] ^ ~addnot_sub;   // subtraction = add of negated b
    assign ea_f = a[N_BIT-2:M];
    assign eb_f = b[N_BIT-2:M];
    assign ma_f = a[M-1:0];
    assign mb_f = b[M-1:0];

    assign a_nan = (ea_f == '1) && (ma_f != '0);
    assign b_nan = (eb_f == '1) && (mb_f != '0);
    assign a_inf = (ea_f == '1) && (ma_f == '0);
    assign b_inf = (eb_f == '1) && (mb_f == '0);

    // effective exponents and significands
    logic [EXP_BIT-1:0] ea, eb;
    logic [W-1:0]       fa, fb;

`ifdef FPADDSUB_SUBNORMAL_EN
    localparam logic [EXP_BIT-1:0] EXP_ONE = EXP_BIT'(1);
    assign ea = (ea_f == '0) ? EXP_ONE : ea_f;
    assign eb = (eb_f == '0) ? EXP_ONE : eb_f;
    assign fa = {(ea_f != '0), ma_f, 3'b000};
    assign fb = {(eb_f != '0), mb_f, 3'b000};
`else
    assign ea = ea_f;
    assign eb = eb_f;
    assign fa = (ea_f == '0) ? '0 : {1'b1, ma_f, 3'b000};
    assign fb = (eb_f == '0) ? '0 : {1'b1, mb_f, 3'b000};
`endif

    logic               a_ge;
    logic [EXP_BIT-1:0] ex, ey, d;
    logic [W-1:0]       fx, fy, fy_al, norm;
    logic               sx, sy, eff_sub;
    logic [W:0]         sum;
    int                 sh, exp_n, exp_r;
    logic               rnd_up, hid_r;
    logic [M+1:0]       rounded;
    logic [M-1:0]       mant_r;
    logic [N_BIT-1:0]   res;

    assign a_ge = {ea, fa} >= {eb, fb};

    // swap, align, add, normalise, round and resolve special cases
    always_comb begin
        ex      = a_ge ? ea : eb;
        ey      = a_ge ? eb : ea;
        fx      = a_ge ? fa : fb;
        fy      = a_ge ? fb : fa;
        sx      = a_ge ? sa : sb;
        sy      = a_ge ? sb : sa;
        eff_sub = sx ^ sy;
        d       = ex - ey;

        // alignment: bits shifted out are OR-ed into sticky
        if (int'(d) >= M + 3) begin
            fy_al = {{(W-1){1'b0}}, |fy};
        end else begin
            fy_al    = fy >> d;
            fy_al[0] = fy_al[0] | (|(fy & ~({W{1'b1}} << d)));
        end

        sum = eff_sub ? ({1'b0, fx} - {1'b0, fy_al}) : ({1'b0, fx} + {1'b0, fy_al});

        exp_n = int'(ex);
        sh    = 0;
        if (sum[W]) begin
            norm  = {sum[W:2], sum[1] | sum[0]};
            exp_n = exp_n + 1;
        end else begin
            sh = int'(lzc(sum[W-1:0]));
`ifdef FPADDSUB_SUBNORMAL_EN
            // stop at exponent 1; whatever remains is a subnormal
            if (sh > exp_n - 1) sh = exp_n - 1;
`endif
            norm  = sum[W-1:0] << sh;
            exp_n = exp_n - sh;
        end

        // round to nearest, ties to even
        rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded = {1'b0, norm[W-1:3]} + {{(M+1){1'b0}}, rnd_up};
        exp_r   = exp_n;
        if (rounded[M+1]) begin
            exp_r  = exp_n + 1;
            mant_r = rounded[M:1];
        end else begin
            mant_r = rounded[M-1:0];
        end
        hid_r = rounded[M+1] | rounded[M];

        if (a_nan || b_nan) begin
            res = QNAN;
        end else if (a_inf && b_inf && (sa != sb)) begin
            res = QNAN;
        end else if (a_inf) begin
            res = {sa, {EXP_BIT{1'b1}}, {M{1'b0}}};
        end else if (b_inf) begin
            res = {sb, {EXP_BIT{1'b1}}, {M{1'b0}}};
        end else if (sum == '0) begin
            // exact cancellation is +0; like-signed zeros keep their sign
            res = {sx & ~eff_sub, {(N_BIT-1){1'b0}}};
        end else if (exp_r >= EMAX) begin
            res = {sx, {EXP_BIT{1'b1}}, {M{1'b0}}};
        end else if (exp_r < 1) begin
            res = {sx, {(N_BIT-1){1'b0}}};
        end else begin
            res = {sx, hid_r ? exp_r[EXP_BIT-1:0] : {EXP_BIT{1'b0}}, mant_r};
        end
    end

    // output register: capture on valid, hold otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) out <= res;
        end
    end

endmodule

// File: tb/tb_fp_addsub.sv
// Scoreboard bench for fp_addsub at double precision.
module tb_fp_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        addnot_sub;
    logic [63:0] a, b;
    logic [63:0] out;
    logic        out_valid;

    always #5 clk = ~clk;

    fp_addsub #(.N_BIT(64), .EXP_BIT(11)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .addnot_sub (addnot_sub),
        .out        (out),
        .out_valid  (out_valid)
    );

    typedef struct {
        logic [63:0] want;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic issue(input string name, input logic [63:0] x, input logic [63:0] y,
                         input logic op, input logic [63:0] want);
        exp_t t;
        @(negedge clk);
        a          = x;
        b          = y;
        addnot_sub = op;
        in_valid   = 1'b1;
        t.want     = want;
        t.name     = name;
        sb.push_back(t);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // monitor: every presented result is matched against the scoreboard head
    always @(posedge clk) begin
        #1;
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_valid: got out %h with no pending expectation", out);
            end else begin
                e = sb.pop_front();
                check(e.name, out, e.want);
            end
        end
    end

    initial begin
        int budget;
        // reset held for 2 edges with live operands, which must be discarded
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        a          = 64'h3FF0000000000000;
        b          = 64'h4000000000000000;
        addnot_sub = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", out, 64'h0);
        check("reset_valid", {63'b0, out_valid}, 64'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_valid", {63'b0, out_valid}, 64'h0);

        // single add, then valid must drop while out holds
        issue("add_1_2", 64'h3FF0000000000000, 64'h4000000000000000, 1'b1, 64'h4008000000000000);
        idle();
        @(posedge clk);
        #1;
        check("valid_one_cycle", {63'b0, out_valid}, 64'h0);
        check("out_hold", out, 64'h4008000000000000);

        // back-to-back directed vectors
        issue("sub_3_2",     64'h4008000000000000, 64'h4000000000000000, 1'b0, 64'h3FF0000000000000);
        issue("sub_1_1",     64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 64'h0000000000000000);
        issue("tie_even",    64'h3FF0000000000000, 64'h3CA0000000000000, 1'b1, 64'h3FF0000000000000);
        issue("tie_odd",     64'h3FF0000000000001, 64'h3CA0000000000000, 1'b1, 64'h3FF0000000000002);
        issue("inf_m_inf",   64'h7FF0000000000000, 64'h7FF0000000000000, 1'b0, 64'h7FF8000000000000);
        issue("nan_p_1",     64'h7FF0000000000001, 64'h3FF0000000000000, 1'b1, 64'h7FF8000000000000);
        issue("one_m_nan",   64'h3FF0000000000000, 64'hFFF8000000000000, 1'b0, 64'h7FF8000000000000);
        issue("ovf_inf",     64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b1, 64'h7FF0000000000000);
        issue("one_m_ninf",  64'h3FF0000000000000, 64'hFFF0000000000000, 1'b0, 64'h7FF0000000000000);
        issue("ninf_p_ninf", 64'hFFF0000000000000, 64'hFFF0000000000000, 1'b1, 64'hFFF0000000000000);
        issue("nz_p_nz",     64'h8000000000000000, 64'h8000000000000000, 1'b1, 64'h8000000000000000);
        issue("pz_p_nz",     64'h0000000000000000, 64'h8000000000000000, 1'b1, 64'h0000000000000000);
        issue("neg_cancel",  64'hBFF0000000000000, 64'hBFF0000000000000, 1'b0, 64'h0000000000000000);
        issue("sub_2_3",     64'h4000000000000000, 64'h4008000000000000, 1'b0, 64'hBFF0000000000000);
        issue("add_15_15",   64'h3FF8000000000000, 64'h3FF8000000000000, 1'b1, 64'h4008000000000000);
`ifdef FPADDSUB_SUBNORMAL_EN
        issue("subnormal",   64'h0010000000000000, 64'h000FFFFFFFFFFFFF, 1'b0, 64'h0000000000000001);
`else
        issue("subnormal",   64'h0010000000000000, 64'h000FFFFFFFFFFFFF, 1'b0, 64'h0010000000000000);
`endif
        idle();

        budget = 20;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: no result presented, expected %h", e.name, e.want);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_addsub.md
# fp_addsub

Parameterised IEEE-754 binary floating-point adder/subtractor. It computes `a + b` or `a - b` on packed operands of configurable total width and exponent width, and registers the result. At the default configuration, N_BIT=64 and EXP_BIT=11, it operates on IEEE double precision. It is the add/subtract unit of the FP datapath and is used anywhere a single-cycle-issue FP add is needed.

## Interface
- `N_BIT`, default 64: total operand width.
- `EXP_BIT`, default 11: exponent field width. Mantissa width is `M = N_BIT-EXP_BIT-1`. Bias is `2^(EXP_BIT-1)-1`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operands valid this cycle.
- `a`  in  N_BIT  operand A, packed as sign|exponent|mantissa.
- `b`  in  N_BIT  operand B, same packing.
- `addnot_sub`  in  1  1 = compute `a+b`; 0 = compute `a-b`.
- `out`  out  N_BIT  registered result.
- `out_valid`  out  1  `out` holds the result of the operands accepted on the previous cycle.

## Operation
- Subtraction is performed as `a + (-b)`: flip the sign of b when `addnot_sub=0`, including when b is NaN.
- Datapath:
  - Unpack both operands and insert the hidden bit (1 for normal, 0 for exponent field 0).
  - Swap so the larger magnitude is first.
  - Right-shift the smaller mantissa by the exponent difference, keeping guard, round and sticky bits. A shift of M+3 or more collapses to sticky only.
  - Add or subtract the mantissas according to the effective sign.
  - Normalise: right-shift by 1 on carry-out, or left-shift by the leading-zero count.
  - Round to nearest, ties to even.
  - Renormalise if rounding overflows the mantissa.
- Result sign is the sign of the larger-magnitude operand.
- Exact cancellation (x − x) gives +0. (−0)+(−0) gives −0. (+0)+(−0) gives +0.
- Exponent overflow after rounding gives signed infinity.
- Special cases, in priority order:
  - Any NaN input → canonical quiet NaN: sign 0, exponent all-ones, mantissa MSB 1, all other bits 0.
  - +inf combined with −inf, as effective operands → canonical quiet NaN.
  - Single infinity → that infinity, with its effective sign.
- No exception flags are produced.

## Timing
- Reset (`rst_n=0` at a clock edge): `out` ← 0 and `out_valid` ← 0. Operands presented in a reset cycle are discarded.
- Latency is 1 cycle, with full throughput. Operands sampled at edge k appear on `out` after edge k with `out_valid=1`.
- When `in_valid=0` at an edge, `out_valid` ← 0 and `out` holds its previous value.
- No backpressure; the consumer must accept the result in the cycle `out_valid` is high.
- Reset asserted while a result is pending clears that result; it is never presented.
- The combinational path from `a`/`b`/`addnot_sub` to the output register must close timing at the system clock. The module has no internal pipeline stages.

## Configuration
- `FPADDSUB_SUBNORMAL_EN` defined:
  - Subnormal inputs are used with exponent 1 and hidden bit 0.
  - Results below the normal range are produced as correctly rounded subnormals.
- `FPADDSUB_SUBNORMAL_EN` undefined:
  - Flush-to-zero. Subnormal inputs are treated as zero, keeping their sign.
  - Any result whose rounded exponent falls below 1 is replaced by zero carrying the result sign.
  - Normal, inf and NaN behaviour is identical in both builds.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles, then release → `out=0`, `out_valid=0`. After that, one valid add of 1.0 + 2.0 → `out_valid=1` for exactly one cycle.
- Default params, `addnot_sub=1`, a=0x3FF0000000000000 (1.0), b=0x4000000000000000 (2.0) → next cycle `out=0x4008000000000000` (3.0).
- `addnot_sub=0`, a=3.0 (0x4008000000000000), b=2.0 → `out=0x3FF0000000000000`. Then a=b=1.0 → `out=0x0000000000000000` (+0).
- Rounding ties: 1.0 + 2^-53 (b=0x3CA0000000000000) → `out=0x3FF0000000000000`. 0x3FF0000000000001 + 2^-53 → `out=0x3FF0000000000002`.
- Specials:
  - +inf (0x7FF0000000000000) − +inf → 0x7FF8000000000000.
  - NaN + 1.0 → 0x7FF8000000000000.
  - 0x7FEFFFFFFFFFFFFF + 0x7FEFFFFFFFFFFFFF → 0x7FF0000000000000.
- Subnormal, run under both builds: 0x0010000000000000 − 0x000FFFFFFFFFFFFF → 0x0000000000000001 with `FPADDSUB_SUBNORMAL_EN` defined; with it undefined, b is flushed to zero and the result is 0x0010000000000000.
